// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state codes, the
// lock-loss counter width and a small elaboration-time helper.
package pll_sup_pkg;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_STABLE    = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;
  localparam logic [1:0] ST_HOLD      = 2'd3;

  localparam int LOST_CNT_W = 8;
  localparam logic [LOST_CNT_W-1:0] LOST_CNT_MAX = '1;

  typedef logic [1:0]            sup_state_t;
  typedef logic [LOST_CNT_W-1:0] lost_cnt_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level; all stages clear
// to 0 on the asynchronous active-low reset.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("bit_sync: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Holds the system in reset until the PLL lock flag has been stable for
// STABLE_CYCLES, and enforces a minimum reset hold after every lock loss.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  locked,
  output logic                  sys_reset_n,
  output logic                  lock_lost,
  output logic [LOST_CNT_W-1:0] lost_count,
  output logic [1:0]            state
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("pll_lock_supervisor: SYNC_STAGES must be in 2..4");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
    $error("pll_lock_supervisor: STABLE_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
    $error("pll_lock_supervisor: HOLD_CYCLES must be >= 1");
  end

  // One counter times both the STABLE qualification and the HOLD window.
  localparam int CNT_W = $clog2(max_int(STABLE_CYCLES, HOLD_CYCLES) + 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  function automatic lost_cnt_t sat_inc(input lost_cnt_t v);
    return (v == LOST_CNT_MAX) ? v : v + lost_cnt_t'(1);
  endfunction

  logic             locked_s;
  sup_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             loss_evt;
  logic             cnt_run;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (locked),
    .q       (locked_s)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT_LOCK: begin
        if (locked_s) state_nxt = ST_STABLE;
      end
      ST_STABLE: begin
        if (!locked_s)                state_nxt = ST_WAIT_LOCK;
        else if (cnt == STABLE_LAST)  state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_s) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        // The hold window ignores locked entirely.
        if (cnt == HOLD_LAST) state_nxt = ST_WAIT_LOCK;
      end
      default: state_nxt = ST_WAIT_LOCK;
    endcase
  end

  assign loss_evt = (state == ST_RUN) && !locked_s;
  assign cnt_run  = (state_nxt == state) &&
                    ((state == ST_STABLE) || (state == ST_HOLD));

  // State, counter and outputs all move on the same edge, so sys_reset_n
  // and lock_lost are plain flops with no path from locked.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_WAIT_LOCK;
      cnt         <= '0;
      sys_reset_n <= 1'b0;
      lock_lost   <= 1'b0;
      lost_count  <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_run ? cnt + CNT_W'(1) : '0;
      sys_reset_n <= (state_nxt == ST_RUN);
      lock_lost   <= loss_evt;
      if (loss_evt) lost_count <= sat_inc(lost_count);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed, table-driven bench for pll_lock_supervisor with
// SYNC_STAGES=2, STABLE_CYCLES=16, HOLD_CYCLES=4.
module tb_pll_lock_supervisor;

  logic       clock;
  logic       reset_n;
  logic       locked;
  logic       sys_reset_n;
  logic       lock_lost;
  logic [7:0] lost_count;
  logic [1:0] state;

  pll_lock_supervisor #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (16),
    .HOLD_CYCLES   (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .locked      (locked),
    .sys_reset_n (sys_reset_n),
    .lock_lost   (lock_lost),
    .lost_count  (lost_count),
    .state       (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst_n;
    logic       lk;
    logic       sys;
    logic       ll;
    logic [7:0] cnt;
    logic [1:0] st;
  } vec_t;

  vec_t vq[$];
  int   n_cmp;
  int   n_fail;
  int   n_pulse;
  int   vec_idx;

  task automatic push(input int r, input int l, input int s, input int ll,
                      input int c, input int st);
    vec_t v;
    v.rst_n = 1'(r);
    v.lk    = 1'(l);
    v.sys   = 1'(s);
    v.ll    = 1'(ll);
    v.cnt   = 8'(c);
    v.st    = 2'(st);
    vq.push_back(v);
  endtask

  // Apply each record before an edge, compare the outputs 1 ns after it.
  task automatic play();
    foreach (vq[i]) begin
      reset_n = vq[i].rst_n;
      locked  = vq[i].lk;
      @(posedge clock);
      #1;
      n_cmp++;
      if (lock_lost === 1'b1) n_pulse++;
      if (sys_reset_n !== vq[i].sys || lock_lost !== vq[i].ll ||
          lost_count !== vq[i].cnt || state !== vq[i].st) begin
        n_fail++;
        $display("FAIL vec[%0d] got sys=%0b ll=%0b cnt=%0d st=%0d, want sys=%0b ll=%0b cnt=%0d st=%0d",
                 vec_idx, sys_reset_n, lock_lost, lost_count, state,
                 vq[i].sys, vq[i].ll, vq[i].cnt, vq[i].st);
      end
      vec_idx++;
    end
    vq.delete();
  endtask

  task automatic check_rst(input string tag);
    n_cmp++;
    if (sys_reset_n !== 1'b0 || lock_lost !== 1'b0 ||
        lost_count !== 8'd0 || state !== 2'd0) begin
      n_fail++;
      $display("FAIL %s got sys=%0b ll=%0b cnt=%0d st=%0d, want sys=0 ll=0 cnt=0 st=0",
               tag, sys_reset_n, lock_lost, lost_count, state);
    end
  endtask

  // Reset pulse entirely between two clock edges.
  task automatic rst_pulse(input string tag);
    #2 reset_n = 1'b0;
    #1 check_rst({tag, "_low"});
    #1 reset_n = 1'b1;
    #1 check_rst({tag, "_released"});
  endtask

  // Edges 1..19 after the first edge that samples locked=1.
  task automatic bring_up(input int lost);
    push(1, 1, 0, 0, lost, 0);
    push(1, 1, 0, 0, lost, 0);
    for (int i = 3; i <= 18; i++) push(1, 1, 0, 0, lost, 1);
    push(1, 1, 1, 0, lost, 2);
  endtask

  // From RUN: one low sample, then locked high; 24 edges back to RUN.
  task automatic loss_relock(input int prev);
    int nxt;
    nxt = (prev < 255) ? prev + 1 : 255;
    push(1, 0, 1, 0, prev, 2);
    push(1, 1, 1, 0, prev, 2);
    push(1, 1, 0, 1, nxt, 3);
    for (int i = 4; i <= 6; i++) push(1, 1, 0, 0, nxt, 3);
    push(1, 1, 0, 0, nxt, 0);
    for (int i = 8; i <= 23; i++) push(1, 1, 0, 0, nxt, 1);
    push(1, 1, 1, 0, nxt, 2);
  endtask

  initial begin
    int prev;
    n_cmp   = 0;
    n_fail  = 0;
    n_pulse = 0;
    vec_idx = 0;
    reset_n = 1'b1;
    locked  = 1'b1;

    // Asynchronous reset with locked high, checked before any clock edge.
    #2 reset_n = 1'b0;
    #1 check_rst("async_reset");

    push(0, 1, 0, 0, 0, 0);
    push(0, 1, 0, 0, 0, 0);
    bring_up(0);
    for (int i = 0; i < 3; i++) push(1, 1, 1, 0, 0, 2);
    play();

    // Short lock glitch during STABLE: no loss event, requalification.
    push(0, 1, 0, 0, 0, 0);
    push(1, 1, 0, 0, 0, 0);
    push(1, 1, 0, 0, 0, 0);
    for (int i = 3; i <= 10; i++) push(1, 1, 0, 0, 0, 1);
    push(1, 0, 0, 0, 0, 1);
    push(1, 1, 0, 0, 0, 1);
    push(1, 1, 0, 0, 0, 0);
    for (int i = 14; i <= 29; i++) push(1, 1, 0, 0, 0, 1);
    push(1, 1, 1, 0, 0, 2);
    play();

    // Loss in RUN with immediate relock, then a loss with locked held low.
    loss_relock(0);
    push(1, 0, 1, 0, 1, 2);
    push(1, 0, 1, 0, 1, 2);
    push(1, 0, 0, 1, 2, 3);
    for (int i = 4; i <= 6; i++) push(1, 0, 0, 0, 2, 3);
    push(1, 0, 0, 0, 2, 0);
    push(1, 0, 0, 0, 2, 0);
    bring_up(2);
    play();

    // 260 loss/relock cycles: counter saturates, every pulse still fires.
    push(0, 1, 0, 0, 0, 0);
    bring_up(0);
    play();
    n_pulse = 0;
    prev = 0;
    for (int k = 0; k < 260; k++) begin
      loss_relock(prev);
      prev = (prev < 255) ? prev + 1 : 255;
    end
    play();
    n_cmp++;
    if (n_pulse != 260) begin
      n_fail++;
      $display("FAIL pulse_count got %0d, want 260", n_pulse);
    end
    n_cmp++;
    if (lost_count !== 8'd255) begin
      n_fail++;
      $display("FAIL lost_count_sat got %0d, want 255", lost_count);
    end

    // Reset pulse mid-STABLE (counter at 8), then full requalification.
    push(0, 1, 0, 0, 0, 0);
    push(1, 1, 0, 0, 0, 0);
    push(1, 1, 0, 0, 0, 0);
    for (int i = 3; i <= 11; i++) push(1, 1, 0, 0, 0, 1);
    play();
    rst_pulse("mid_stable");
    bring_up(0);
    loss_relock(0);
    loss_relock(1);
    push(1, 0, 1, 0, 2, 2);
    push(1, 1, 1, 0, 2, 2);
    push(1, 1, 0, 1, 3, 3);
    push(1, 1, 0, 0, 3, 3);
    play();

    // Reset pulse mid-HOLD with lost_count at 3.
    rst_pulse("mid_hold_lost3");
    bring_up(0);
    play();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for locked, legal range 2..4.
REQ-002 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-high cycles required before reset release, legal range >=1.
REQ-003 SHALL have parameter HOLD_CYCLES, default 16: minimum reset assertion after a lock loss, legal range >=1.
REQ-004 SHALL have port clock  input  1: 65 MHz PLL output clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port locked  input  1: PLL lock flag, asynchronous to clock.
REQ-007 SHALL have port sys_reset_n  output  1: registered system reset, low = held in reset.
REQ-008 SHALL have port lock_lost  output  1: one-cycle pulse per lock loss detected in RUN.
REQ-009 SHALL have port lost_count  output  8: lock-loss event counter, saturating.
REQ-010 SHALL have port state  output  2: current FSM state code.

Function
REQ-011 SHALL pass locked through SYNC_STAGES flops; only the last stage (locked_s) feeds the FSM.
REQ-012 SHALL implement states WAIT_LOCK=0, STABLE=1, RUN=2, HOLD=3.
REQ-013 WAIT_LOCK: locked_s=1 -> STABLE with stable counter cleared; else stay.
REQ-014 STABLE: locked_s=0 -> WAIT_LOCK, no lock_lost pulse, no count change; counter==STABLE_CYCLES-1 -> RUN; else increment.
REQ-015 sys_reset_n SHALL be 1 exactly while state==RUN, registered with the state (no combinational path from locked).
REQ-016 Latency: with locked held high, sys_reset_n SHALL rise on edge SYNC_STAGES+STABLE_CYCLES+1, the first edge sampling locked=1 being edge 1.
REQ-017 RUN: locked_s=0 -> HOLD; on that same edge sys_reset_n->0, lock_lost->1 for exactly one cycle, lost_count increments.
REQ-018 lost_count SHALL saturate at 255; lock_lost SHALL still pulse when saturated.
REQ-019 HOLD: SHALL stay exactly HOLD_CYCLES cycles regardless of locked, then -> WAIT_LOCK.
REQ-020 A single counter, width $clog2(max(STABLE_CYCLES,HOLD_CYCLES)+1), SHALL serve STABLE and HOLD; it SHALL clear on every state transition.
REQ-021 lock_lost SHALL be 0 in all cycles other than those given by REQ-017.

Reset
REQ-022 reset_n low SHALL immediately, without a clock edge, force: sync flops 0, state=WAIT_LOCK, counter 0, sys_reset_n=0, lock_lost=0, lost_count=0.
REQ-023 Reset asserted in any state, including mid-STABLE or mid-HOLD, SHALL abort the sequence; after release, qualification restarts from edge 1 per REQ-016.
REQ-024 reset_n deassertion is synchronized externally; the block adds no reset synchronizer.

Structure
REQ-025 State encodings and the 8-bit lost_count width SHALL live in shared package pll_sup_pkg.
REQ-026 The synchronizer SHALL be sub-module bit_sync (parameter STAGES, async active-low reset to 0); the FSM, counter and outputs stay in pll_lock_supervisor.
REQ-027 Illegal parameter values SHALL fail elaboration.

Verification (STABLE_CYCLES=16, HOLD_CYCLES=4, SYNC_STAGES=2)
REQ-028 reset_n=0, locked=1 -> sys_reset_n=0, state=0, lost_count=0; release reset_n, locked held 1 -> sys_reset_n rises on edge 19, state=2.
REQ-029 locked high 10 cycles, low 1 cycle, high again -> lock_lost never 1, lost_count=0, sys_reset_n rises 19 edges after locked returns.
REQ-030 In RUN, drop locked -> on edge 3 sys_reset_n=0, state=3, lock_lost=1 one cycle, lost_count=1; locked re-raised immediately -> HOLD lasts 4 cycles, then WAIT_LOCK, then full 16-cycle requalification.
REQ-031 260 loss/relock cycles -> lost_count=255 after the 255th, stays 255; 260 lock_lost pulses counted.
REQ-032 reset_n pulsed low between edges at STABLE counter=8 (and separately with lost_count=3) -> all outputs at reset values before the next edge; lost_count=0.
